// File: rtl/demosaic_root_udiv_seq.sv
// Sequential restoring divider: one quotient bit per cycle, start/done handshake, saturated quotient.
// Optional round-half-up quotient when DEMOSAIC_ROOT_UDIV_ROUND_EN is defined.
module demosaic_root_udiv_seq #(
    parameter int unsigned din0_WIDTH = 25,
    parameter int unsigned din1_WIDTH = 8,
    parameter int unsigned dout_WIDTH = 18
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  ap_start,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  ap_ready,
    output logic                  ap_idle,
    output logic                  ap_done,
    output logic [dout_WIDTH-1:0] dout,
    output logic [din1_WIDTH-1:0] rem,
    output logic                  ovf,
    output logic                  div0
);

    localparam int unsigned N  = din0_WIDTH;
    localparam int unsigned M  = din1_WIDTH;
    localparam int unsigned Q  = dout_WIDTH;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state_q;
    logic [CW-1:0] cnt_q;
    // Dividend bits shift out of the top while quotient bits shift in at the bottom.
    logic [N-1:0]  dq_q;
    logic [M:0]    part_q;
    logic [M-1:0]  div_q;
    logic [M-1:0]  lo_q;
    logic [Q-1:0]  dout_q;
    logic [M-1:0]  rem_q;
    logic          ovf_q;
    logic          div0_q;

    logic [M:0]    rem_sh;
    logic          ge;
    logic [M:0]    rem_nx;
    logic [N-1:0]  q_nx;
    logic          rnd;
    logic [N:0]    quo_ext;
    logic          sat;
    logic [Q-1:0]  res_dout;
    logic          accept;

    always_comb begin
        rem_sh = {part_q[M-1:0], dq_q[N-1]};
        ge     = (rem_sh >= {1'b0, div_q});
        rem_nx = ge ? (rem_sh - {1'b0, div_q}) : rem_sh;
        q_nx   = {dq_q[N-2:0], ge};
`ifdef DEMOSAIC_ROOT_UDIV_ROUND_EN
        rnd    = ({rem_nx[M-1:0], 1'b0} >= {1'b0, div_q});
`else
        rnd    = 1'b0;
`endif
        // Extra top bit catches a carry out of the rounding increment.
        quo_ext  = {1'b0, q_nx} + {{N{1'b0}}, rnd};
        sat      = ((quo_ext >> Q) != '0);
        res_dout = sat ? {Q{1'b1}} : quo_ext[Q-1:0];
    end

    assign accept   = ap_start && (state_q != CALC);
    assign ap_ready = (state_q != CALC);
    assign ap_idle  = (state_q != CALC);
    assign ap_done  = (state_q == DONE);
    assign dout     = dout_q;
    assign rem      = rem_q;
    assign ovf      = ovf_q;
    assign div0     = div0_q;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dq_q    <= '0;
            part_q  <= '0;
            div_q   <= '0;
            lo_q    <= '0;
            dout_q  <= '0;
            rem_q   <= '0;
            ovf_q   <= 1'b0;
            div0_q  <= 1'b0;
        end else if (accept) begin
            state_q <= CALC;
            cnt_q   <= CW'(N - 1);
            dq_q    <= din0;
            part_q  <= '0;
            div_q   <= din1;
            lo_q    <= din0[M-1:0];
        end else if (state_q == CALC) begin
            dq_q   <= q_nx;
            part_q <= rem_nx;
            cnt_q  <= cnt_q - CW'(1);
            if (cnt_q == '0) begin
                state_q <= DONE;
                // Divide-by-zero still runs the full sequence; its result is overridden here.
                if (div_q == '0) begin
                    dout_q <= {Q{1'b1}};
                    rem_q  <= lo_q;
                    ovf_q  <= 1'b0;
                    div0_q <= 1'b1;
                end else begin
                    dout_q <= res_dout;
                    rem_q  <= rem_nx[M-1:0];
                    ovf_q  <= sat;
                    div0_q <= 1'b0;
                end
            end
        end else if (state_q == DONE) begin
            state_q <= IDLE;
        end
    end

endmodule

// File: tb/tb_demosaic_root_udiv_seq.sv
// Self-checking bench for demosaic_root_udiv_seq: directed cases plus random divisions
// checked against a plain-arithmetic reference model.
module tb_demosaic_root_udiv_seq;

    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic        ap_start;
    logic [24:0] din0;
    logic [7:0]  din1;
    logic        ap_ready;
    logic        ap_idle;
    logic        ap_done;
    logic [17:0] dout;
    logic [7:0]  rem;
    logic        ovf;
    logic        div0;

    int errors = 0;
    int checks = 0;

    demosaic_root_udiv_seq dut (
        .ap_clk   (ap_clk),
        .ap_rst   (ap_rst),
        .ap_start (ap_start),
        .din0     (din0),
        .din1     (din1),
        .ap_ready (ap_ready),
        .ap_idle  (ap_idle),
        .ap_done  (ap_done),
        .dout     (dout),
        .rem      (rem),
        .ovf      (ovf),
        .div0     (div0)
    );

    always #5 ap_clk = ~ap_clk;

    function automatic void model(input logic [24:0] a, input logic [7:0] b,
                                  output logic [17:0] q, output logic [7:0] r,
                                  output logic o, output logic z);
        longint unsigned qq;
        longint unsigned rr;
        if (b == 8'd0) begin
            q = 18'h3FFFF;
            r = a[7:0];
            o = 1'b0;
            z = 1'b1;
        end else begin
            qq = longint'(a) / longint'(b);
            rr = longint'(a) % longint'(b);
`ifdef DEMOSAIC_ROOT_UDIV_ROUND_EN
            if (2 * rr >= longint'(b)) qq = qq + 1;
`endif
            o = (qq > 64'h3FFFF);
            q = o ? 18'h3FFFF : qq[17:0];
            r = rr[7:0];
            z = 1'b0;
        end
    endfunction

    // Launch one division and wait for ap_done; lat is cycles from the start cycle, -1 on timeout.
    task automatic do_div(input logic [24:0] a, input logic [7:0] b, output int lat);
        din0 = a;
        din1 = b;
        ap_start = 1'b1;
        @(posedge ap_clk); #1;
        ap_start = 1'b0;
        din0 = 25'($urandom);
        din1 = 8'($urandom);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            if (ap_done) begin
                lat = k;
                break;
            end
            @(posedge ap_clk); #1;
        end
    endtask

    task automatic test_reset;
        ap_rst = 1'b1;
        ap_start = 1'b1;
        din0 = 25'd1000;
        din1 = 8'd7;
        repeat (3) @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;
        ap_start = 1'b0;
        checks++;
        if ({ap_ready, ap_idle, ap_done} !== 3'b110) begin
            errors++;
            $display("FAIL reset_hs: got rdy/idle/done=%b want 110", {ap_ready, ap_idle, ap_done});
        end
        checks++;
        if ({dout, rem, ovf, div0} !== 28'd0) begin
            errors++;
            $display("FAIL reset_out: got dout=%h rem=%h ovf=%b div0=%b want all 0",
                     dout, rem, ovf, div0);
        end
        @(posedge ap_clk); #1;
        checks++;
        if (ap_done !== 1'b0 || ap_idle !== 1'b1) begin
            errors++;
            $display("FAIL reset_wins: got done=%b idle=%b want 0 1", ap_done, ap_idle);
        end
    endtask

    task automatic test_basic;
        int lat;
        logic [17:0] exp_q;
`ifdef DEMOSAIC_ROOT_UDIV_ROUND_EN
        exp_q = 18'd143;
`else
        exp_q = 18'd142;
`endif
        do_div(25'd1000, 8'd7, lat);
        checks++;
        if (lat !== 26) begin
            errors++;
            $display("FAIL basic_lat: got %0d want 26", lat);
        end
        checks++;
        if (dout !== exp_q || rem !== 8'd6 || ovf !== 1'b0 || div0 !== 1'b0) begin
            errors++;
            $display("FAIL basic_res: got dout=%0d rem=%0d ovf=%b div0=%b want %0d 6 0 0",
                     dout, rem, ovf, div0, exp_q);
        end
        @(posedge ap_clk); #1;
        checks++;
        if (ap_done !== 1'b0 || dout !== exp_q) begin
            errors++;
            $display("FAIL basic_pulse: got done=%b dout=%0d want 0 %0d", ap_done, dout, exp_q);
        end
    endtask

    task automatic test_overflow;
        int lat;
        do_div(25'h1FFFFFF, 8'd1, lat);
        checks++;
        if (lat !== 26 || dout !== 18'h3FFFF || rem !== 8'd0 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_big: got lat=%0d dout=%h rem=%h ovf=%b want 26 3ffff 0 1",
                     lat, dout, rem, ovf);
        end
        do_div(25'h3FFFF, 8'd1, lat);
        checks++;
        if (dout !== 18'h3FFFF || rem !== 8'd0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_edge: got dout=%h rem=%h ovf=%b want 3ffff 0 0", dout, rem, ovf);
        end
        @(posedge ap_clk); #1;
    endtask

    task automatic test_div0;
        int lat;
        do_div(25'h0000AB, 8'd0, lat);
        checks++;
        if (lat !== 26) begin
            errors++;
            $display("FAIL div0_lat: got %0d want 26", lat);
        end
        checks++;
        if (dout !== 18'h3FFFF || rem !== 8'hAB || div0 !== 1'b1 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL div0_res: got dout=%h rem=%h div0=%b ovf=%b want 3ffff ab 1 0",
                     dout, rem, div0, ovf);
        end
        @(posedge ap_clk); #1;
    endtask

    task automatic test_back_to_back;
        int lat;
        logic [17:0] eq;
        logic [7:0]  er;
        logic        eo;
        logic        ez;
        din0 = 25'd255;
        din1 = 8'd16;
        ap_start = 1'b1;
        @(posedge ap_clk); #1;
        ap_start = 1'b0;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            if (k == 5) begin
                ap_start = 1'b1;
                din0 = 25'd999;
                din1 = 8'd2;
                checks++;
                if (ap_ready !== 1'b0 || ap_idle !== 1'b0) begin
                    errors++;
                    $display("FAIL busy_ready: got rdy=%b idle=%b want 0 0", ap_ready, ap_idle);
                end
            end else if (k == 6) begin
                ap_start = 1'b0;
            end else if (k == 24) begin
                ap_start = 1'b1;
                din0 = 25'd300;
                din1 = 8'd3;
            end
            if (ap_done) begin
                lat = k;
                break;
            end
            @(posedge ap_clk); #1;
        end
        model(25'd255, 8'd16, eq, er, eo, ez);
        checks++;
        if (lat !== 26 || dout !== eq || rem !== er) begin
            errors++;
            $display("FAIL busy_first: got lat=%0d dout=%0d rem=%0d want 26 %0d %0d",
                     lat, dout, rem, eq, er);
        end
        @(posedge ap_clk); #1;
        ap_start = 1'b0;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            if (ap_done) begin
                lat = k;
                break;
            end
            @(posedge ap_clk); #1;
        end
        checks++;
        if (lat !== 26 || dout !== 18'd100 || rem !== 8'd0) begin
            errors++;
            $display("FAIL b2b_second: got lat=%0d dout=%0d rem=%0d want 26 100 0", lat, dout, rem);
        end
        @(posedge ap_clk); #1;
    endtask

    task automatic test_reset_mid;
        int lat;
        int seen;
        din0 = 25'd1000;
        din1 = 8'd7;
        ap_start = 1'b1;
        @(posedge ap_clk); #1;
        ap_start = 1'b0;
        repeat (9) @(posedge ap_clk);
        #1;
        ap_rst = 1'b1;
        @(posedge ap_clk); #1;
        ap_rst = 1'b0;
        checks++;
        if ({ap_ready, ap_idle, ap_done} !== 3'b110 || {dout, rem, ovf, div0} !== 28'd0) begin
            errors++;
            $display("FAIL rstmid_out: got rdy/idle/done=%b dout=%h rem=%h ovf=%b div0=%b want 110 0",
                     {ap_ready, ap_idle, ap_done}, dout, rem, ovf, div0);
        end
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (ap_done) seen++;
            @(posedge ap_clk); #1;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL rstmid_nodone: got %0d done cycles want 0", seen);
        end
        do_div(25'd50, 8'd5, lat);
        checks++;
        if (lat !== 26 || dout !== 18'd10 || rem !== 8'd0) begin
            errors++;
            $display("FAIL rstmid_next: got lat=%0d dout=%0d rem=%0d want 26 10 0", lat, dout, rem);
        end
        @(posedge ap_clk); #1;
    endtask

    task automatic test_random;
        int lat;
        logic [24:0] a;
        logic [7:0]  b;
        logic [17:0] eq;
        logic [7:0]  er;
        logic        eo;
        logic        ez;
        for (int i = 0; i < 24; i++) begin
            a = 25'($urandom);
            case ($urandom_range(3))
                0: b = 8'd0;
                1: b = 8'($urandom_range(1, 4));
                default: b = 8'($urandom);
            endcase
            if (i % 3 == 0) a = a >> $urandom_range(12);
            model(a, b, eq, er, eo, ez);
            do_div(a, b, lat);
            checks++;
            if (lat !== 26 || dout !== eq || rem !== er || ovf !== eo || div0 !== ez) begin
                errors++;
                $display("FAIL rand_%0d: %0d/%0d got lat=%0d q=%h r=%h o=%b z=%b want 26 %h %h %b %b",
                         i, a, b, lat, dout, rem, ovf, div0, eq, er, eo, ez);
            end
            // Odd iterations go straight back in from DONE.
            if (i % 2 == 0) begin
                @(posedge ap_clk); #1;
            end
        end
        @(posedge ap_clk); #1;
    endtask

`ifdef DEMOSAIC_ROOT_UDIV_ROUND_EN
    task automatic test_rounding;
        int lat;
        logic [24:0] av [3];
        logic [7:0]  bv [3];
        logic [17:0] qv [3];
        logic [7:0]  rv [3];
        av = '{25'd9, 25'd8, 25'd7};
        bv = '{8'd2, 8'd3, 8'd3};
        qv = '{18'd5, 18'd3, 18'd2};
        rv = '{8'd1, 8'd2, 8'd1};
        for (int i = 0; i < 3; i++) begin
            do_div(av[i], bv[i], lat);
            checks++;
            if (dout !== qv[i] || rem !== rv[i] || ovf !== 1'b0) begin
                errors++;
                $display("FAIL round_%0d: got dout=%0d rem=%0d ovf=%b want %0d %0d 0",
                         i, dout, rem, ovf, qv[i], rv[i]);
            end
            @(posedge ap_clk); #1;
        end
    endtask
`endif

    initial begin
        ap_rst = 1'b1;
        ap_start = 1'b0;
        din0 = '0;
        din1 = '0;
        test_reset;
        test_basic;
        test_overflow;
        test_div0;
        test_back_to_back;
        test_reset_mid;
        test_random;
`ifdef DEMOSAIC_ROOT_UDIV_ROUND_EN
        test_rounding;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
